// File: rtl/prng_pkg.sv
// -----------------------------------------------------------------------------
// prng_pkg
// Shared constants and the Galois LFSR step function for the PRNG bank.
//   POLY_DEFAULT / SEED_DEFAULT : default feedback mask and base reset seed
//   POLY_W8/16/24/32            : maximal-length Galois masks per width
//   prng_step()                 : one right-shifting Galois step on a
//                                 zero-extended state (upper bits stay zero
//                                 when state and mask are zero-extended)
// -----------------------------------------------------------------------------
package prng_pkg;

  localparam logic [31:0] POLY_DEFAULT = 32'h8020_0003;
  localparam logic [31:0] SEED_DEFAULT = 32'hACE1_2468;

  // Maximal-length feedback masks for the common widths.
  localparam logic [31:0] POLY_W8  = 32'h0000_00B8;
  localparam logic [31:0] POLY_W16 = 32'h0000_B400;
  localparam logic [31:0] POLY_W24 = 32'h00E1_0000;
  localparam logic [31:0] POLY_W32 = 32'h8020_0003;

  // Galois step: shift right, fold the mask in when the bit shifted out is 1.
  function automatic logic [31:0] prng_step(input logic [31:0] s,
                                            input logic [31:0] poly);
    return (s >> 1) ^ (s[0] ? poly : 32'h0);
  endfunction

endpackage : prng_pkg

// File: rtl/prng_channel.sv
// -----------------------------------------------------------------------------
// prng_channel
// One Galois LFSR with its own seed register and period-complete detect.
// Ports:
//   clk        : clock, all state updates on the rising edge
//   rst        : synchronous active-high reset, loads RESET_SEED
//   step_i     : advance the LFSR this cycle
//   seed_we_i  : load seed_i into state and seed register (wins over step_i)
//   seed_i     : seed value; zero is replaced by 1
//   state_o    : current LFSR state (straight from the register)
//   valid_o    : registered, high the cycle after a step
//   wrap_o     : registered, high with valid_o when the new state equals the
//                seed register (one pulse per full period)
// -----------------------------------------------------------------------------
module prng_channel
  import prng_pkg::*;
#(
  parameter int unsigned      WIDTH      = 32,
  parameter logic [WIDTH-1:0] POLY       = POLY_DEFAULT[WIDTH-1:0],
  parameter logic [WIDTH-1:0] RESET_SEED = SEED_DEFAULT[WIDTH-1:0]
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step_i,
  input  logic             seed_we_i,
  input  logic [WIDTH-1:0] seed_i,
  output logic [WIDTH-1:0] state_o,
  output logic             valid_o,
  output logic             wrap_o
);

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] seed_q;
  logic [WIDTH-1:0] seed_fixed;
  logic [31:0]      next_wide;
  logic             next_is_seed;

  // An all-zero state is a fixed point of the LFSR, so never load it.
  assign seed_fixed = (seed_i == '0) ? WIDTH'(1) : seed_i;

  assign next_wide = prng_step(32'(state_q), 32'(POLY));

  // Compared at full width: the bits above WIDTH are zero by construction.
  assign next_is_seed = (next_wide == 32'(seed_q));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the seed register is reset alongside the state
  // because wrap detection depends on it holding a defined value.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RESET_SEED;
      seed_q  <= RESET_SEED;
      valid_o <= 1'b0;
      wrap_o  <= 1'b0;
    end else if (seed_we_i) begin
      // A coincident step is dropped: the freshly written seed is what shows.
      state_o_unused_guard: begin
        state_q <= seed_fixed;
        seed_q  <= seed_fixed;
        valid_o <= 1'b0;
        wrap_o  <= 1'b0;
      end
    end else if (step_i) begin
      state_q <= next_wide[WIDTH-1:0];
      valid_o <= 1'b1;
      wrap_o  <= next_is_seed;
    end else begin
      valid_o <= 1'b0;
      wrap_o  <= 1'b0;
    end
  end

  assign state_o = state_q;

endmodule : prng_channel

// File: rtl/prng_bank.sv
// -----------------------------------------------------------------------------
// prng_bank
// Bank of CHANNELS independent Galois LFSRs sharing one clock.
// Ports:
//   wb_clk_i  : clock
//   wb_rst_i  : synchronous active-high reset; channel i reloads
//               (SEED ^ i), forced to 1 if that is zero
//   en_i      : global enable; low freezes every channel (seed writes still land)
//   mode_i    : 0 = free-run (all step each cycle), 1 = on-demand via req_i
//   req_i     : per-channel step request, on-demand mode only
//   seed_we_i : seed write strobe
//   seed_ch_i : target channel; out-of-range indices are ignored
//   seed_i    : seed value
//   rnd_o     : channel i state at [i*WIDTH +: WIDTH]
//   valid_o   : per-channel "new value" flag, one cycle after a step
//   wrap_o    : per-channel period-complete pulse, coincident with valid_o
// -----------------------------------------------------------------------------
module prng_bank
  import prng_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned CHANNELS = 4,
  parameter logic [31:0] POLY     = POLY_DEFAULT,
  parameter logic [31:0] SEED     = SEED_DEFAULT,
  localparam int unsigned SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic                      en_i,
  input  logic                      mode_i,
  input  logic [CHANNELS-1:0]       req_i,
  input  logic                      seed_we_i,
  input  logic [SEL_W-1:0]          seed_ch_i,
  input  logic [WIDTH-1:0]          seed_i,
  output logic [CHANNELS*WIDTH-1:0] rnd_o,
  output logic [CHANNELS-1:0]       valid_o,
  output logic [CHANNELS-1:0]       wrap_o
);

  localparam logic [WIDTH-1:0] POLY_W = POLY[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SEED_W = SEED[WIDTH-1:0];

  // Step decision uses the current mode, so a mode change applies this cycle.
  logic [CHANNELS-1:0] step;
  assign step = en_i ? (mode_i ? req_i : {CHANNELS{1'b1}}) : '0;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    localparam logic [WIDTH-1:0] RS_RAW = SEED_W ^ WIDTH'(i);
    localparam logic [WIDTH-1:0] RS     = (RS_RAW == '0) ? WIDTH'(1) : RS_RAW;

    // Indices at or above CHANNELS match no channel, so those writes vanish.
    logic seed_hit;
    assign seed_hit = seed_we_i && (int'(seed_ch_i) == i);

    prng_channel #(
      .WIDTH      (WIDTH),
      .POLY       (POLY_W),
      .RESET_SEED (RS)
    ) u_ch (
      .clk       (wb_clk_i),
      .rst       (wb_rst_i),
      .step_i    (step[i]),
      .seed_we_i (seed_hit),
      .seed_i    (seed_i),
      .state_o   (rnd_o[i*WIDTH +: WIDTH]),
      .valid_o   (valid_o[i]),
      .wrap_o    (wrap_o[i])
    );
  end

endmodule : prng_bank

// File: tb/tb_prng_bank.sv
// -----------------------------------------------------------------------------
// tb_prng_bank
// Directed bench for prng_bank with WIDTH=8, CHANNELS=4, POLY=B8, SEED=A5.
// Inputs change 1 ns after the rising edge; outputs are sampled there too,
// so each sample shows the result of the edge just passed.
// -----------------------------------------------------------------------------
module tb_prng_bank;

  localparam int W = 8;
  localparam int C = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           en;
  logic           mode;
  logic [C-1:0]   req;
  logic           seed_we;
  logic [1:0]     seed_ch;
  logic [W-1:0]   seed;
  logic [C*W-1:0] rnd;
  logic [C-1:0]   valid;
  logic [C-1:0]   wrap;

  int n_checks = 0;
  int n_errors = 0;

  // Expected channel states, advanced by the bench's own step model.
  logic [7:0] m [C];
  logic [7:0] ch0_tbl [5] = '{8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3};

  always #5 clk = ~clk;

  prng_bank #(
    .WIDTH    (W),
    .CHANNELS (C),
    .POLY     (32'h0000_00B8),
    .SEED     (32'h0000_00A5)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .en_i      (en),
    .mode_i    (mode),
    .req_i     (req),
    .seed_we_i (seed_we),
    .seed_ch_i (seed_ch),
    .seed_i    (seed),
    .rnd_o     (rnd),
    .valid_o   (valid),
    .wrap_o    (wrap)
  );

  function automatic logic [7:0] model_step(input logic [7:0] s);
    return {1'b0, s[7:1]} ^ (s[0] ? 8'hB8 : 8'h00);
  endfunction

  function automatic logic [31:0] pack_m();
    return {m[3], m[2], m[1], m[0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int wrap_cnt;
    int wrap_at;
    logic [31:0] snap;

    rst = 1'b1; en = 1'b0; mode = 1'b0; req = '0;
    seed_we = 1'b0; seed_ch = '0; seed = '0;
    tick(); tick();
    rst = 1'b0;
    m[0] = 8'hA5; m[1] = 8'hA4; m[2] = 8'hA7; m[3] = 8'hA6;
    check("reset_rnd",   rnd,   32'hA6A7_A4A5);
    check("reset_valid", valid, 4'b0000);
    check("reset_wrap",  wrap,  4'b0000);

    // Seed write while disabled still lands.
    seed_we = 1'b1; seed_ch = 2'd0; seed = 8'h01;
    tick();
    seed_we = 1'b0;
    m[0] = 8'h01;
    check("seed_en0", rnd, pack_m());
    check("seed_en0_valid", valid, 4'b0000);

    // Free-run: known ch0 sequence from seed 01.
    en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      for (int c = 0; c < C; c++) m[c] = model_step(m[c]);
      check($sformatf("free_ch0_%0d", k), 32'(rnd[7:0]), 32'(ch0_tbl[k]));
      check($sformatf("free_all_%0d", k), rnd, pack_m());
      check($sformatf("free_valid_%0d", k), valid, 4'b1111);
    end

    // Freeze for 10 cycles, then resume without skipping.
    en = 1'b0;
    snap = pack_m();
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("frozen_rnd_%0d", k), rnd, snap);
      check($sformatf("frozen_valid_%0d", k), valid, 4'b0000);
    end
    en = 1'b1;
    tick();
    for (int c = 0; c < C; c++) m[c] = model_step(m[c]);
    check("resume_ch0", 32'(rnd[7:0]), 32'h0000_00E1);
    check("resume_all", rnd, pack_m());
    check("resume_valid", valid, 4'b1111);

    // Full period on ch0: exactly one wrap, on step 255, back at 01.
    en = 1'b0; seed_we = 1'b1; seed_ch = 2'd0; seed = 8'h01;
    tick();
    seed_we = 1'b0; m[0] = 8'h01;
    en = 1'b1;
    wrap_cnt = 0; wrap_at = 0;
    for (int k = 1; k <= 255; k++) begin
      tick();
      for (int c = 0; c < C; c++) m[c] = model_step(m[c]);
      if (wrap[0]) begin
        wrap_cnt++;
        wrap_at = k;
      end
    end
    check("wrap_count", wrap_cnt, 1);
    check("wrap_step", wrap_at, 255);
    check("wrap_state", 32'(rnd[7:0]), 32'h01);
    check("wrap_now", 32'(wrap[0]), 32'h1);
    check("wrap_all", rnd, pack_m());

    // On-demand: no request, nothing moves.
    mode = 1'b1; req = 4'b0000;
    tick();
    check("od_idle_rnd", rnd, pack_m());
    check("od_idle_valid", valid, 4'b0000);

    // Single-cycle request on ch1 only.
    req = 4'b0010;
    tick();
    req = 4'b0000;
    m[1] = model_step(m[1]);
    check("od_ch1_rnd", rnd, pack_m());
    check("od_ch1_valid", valid, 4'b0010);
    tick();
    check("od_ch1_after_rnd", rnd, pack_m());
    check("od_ch1_after_valid", valid, 4'b0000);

    // Zero seed becomes 1.
    seed_we = 1'b1; seed_ch = 2'd2; seed = 8'h00;
    tick();
    seed_we = 1'b0;
    m[2] = 8'h01;
    check("seed_zero", 32'(rnd[23:16]), 32'h01);

    // Seed and step on ch2 together: seed wins; ch3 steps normally.
    seed_we = 1'b1; seed_ch = 2'd2; seed = 8'h5A; req = 4'b1100;
    tick();
    seed_we = 1'b0; req = 4'b0000;
    m[2] = 8'h5A; m[3] = model_step(m[3]);
    check("seed_vs_step_rnd", rnd, pack_m());
    check("seed_vs_step_valid", valid, 4'b1000);

    // Held request steps every cycle.
    req = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      tick();
      m[0] = model_step(m[0]);
      check($sformatf("held_rnd_%0d", k), rnd, pack_m());
      check($sformatf("held_valid_%0d", k), valid, 4'b0001);
    end

    // Mode change to free-run applies in the same cycle.
    req = 4'b0000; mode = 1'b0;
    tick();
    for (int c = 0; c < C; c++) m[c] = model_step(m[c]);
    check("mode_switch_rnd", rnd, pack_m());
    check("mode_switch_valid", valid, 4'b1111);

    // Reset mid free-run beats a concurrent seed write.
    rst = 1'b1; seed_we = 1'b1; seed_ch = 2'd0; seed = 8'h33;
    tick();
    rst = 1'b0; seed_we = 1'b0;
    m[0] = 8'hA5; m[1] = 8'hA4; m[2] = 8'hA7; m[3] = 8'hA6;
    check("midrst_rnd",   rnd,   32'hA6A7_A4A5);
    check("midrst_valid", valid, 4'b0000);
    check("midrst_wrap",  wrap,  4'b0000);
    tick();
    for (int c = 0; c < C; c++) m[c] = model_step(m[c]);
    check("post_rst_step", rnd, pack_m());
    check("post_rst_valid", valid, 4'b1111);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_prng_bank

// File: doc/prng_bank.md
PRNG_BANK -- requirements
Module: prng_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 32, LFSR width per channel, legal range 8..32.
REQ-002 SHALL have parameter CHANNELS, default 4, independent generator count, legal range 1..8.
REQ-003 SHALL have parameter POLY, default 32'h80200003, Galois feedback mask (low WIDTH bits used).
REQ-004 SHALL have parameter SEED, default 32'hACE1_2468, base reset seed (low WIDTH bits used).
REQ-005 SHALL have port wb_clk_i, input, 1, single clock for all state; all registers update on its rising edge.
REQ-006 SHALL have port wb_rst_i, input, 1; reset is synchronous and active-high.
REQ-007 SHALL have port en_i, input, 1, global enable; low freezes all channels.
REQ-008 SHALL have port mode_i, input, 1: 0 = free-run, 1 = on-demand.
REQ-009 SHALL have port req_i, input, CHANNELS, per-channel step request; used only in on-demand mode.
REQ-010 SHALL have port seed_we_i, input, 1, seed write strobe.
REQ-011 SHALL have port seed_ch_i, input, clog2(CHANNELS) (min 1), target channel of the seed write.
REQ-012 SHALL have port seed_i, input, WIDTH, seed value.
REQ-013 SHALL have port rnd_o, output, CHANNELS*WIDTH; channel i state occupies bits [i*WIDTH +: WIDTH].
REQ-014 SHALL have port valid_o, output, CHANNELS, per-channel one-cycle "new value" flag.
REQ-015 SHALL have port wrap_o, output, CHANNELS, per-channel period-complete pulse.

Function
REQ-016 Step rule: lsb = s[0]; s_next = (s >> 1) XOR (lsb ? POLY[WIDTH-1:0] : 0).
REQ-017 Free-run (mode_i=0, en_i=1): every channel steps every cycle; valid_o[i] is high the cycle after each step.
REQ-018 On-demand (mode_i=1, en_i=1): channel i steps only when req_i[i]=1 in cycle N; rnd_o shows the new value and valid_o[i]=1 in cycle N+1; a held req_i steps every cycle.
REQ-019 With en_i=0: no step and valid_o all 0 on the next cycle; seed writes are still accepted.
REQ-020 Seed write (seed_we_i=1): state[seed_ch_i] and seedreg[seed_ch_i] load seed_i at the edge; a zero seed_i is replaced by 1 (lock-up avoidance).
REQ-021 seed_ch_i >= CHANNELS: the write is ignored.
REQ-022 A seed write and a step to the same channel in the same cycle: the seed wins, the step is dropped, and valid_o[ch]=0 next cycle; other channels are unaffected.
REQ-023 wrap_o[i] pulses high with valid_o[i] when the stepped state equals seedreg[i]. This pulses once per full period; with WIDTH=8 and POLY=B8 that is every 255 steps.
REQ-024 A mode_i change takes effect on the same cycle's step decision; channel state is preserved.
REQ-025 valid_o and wrap_o are registered and glitch-free; rnd_o is driven directly from the state registers.

Reset
REQ-026 On wb_rst_i=1 at an edge: state[i] = seedreg[i] = (SEED[WIDTH-1:0] XOR i), forced to 1 if the result is 0.
REQ-027 On reset: valid_o = 0 and wrap_o = 0.
REQ-028 Reset has priority over seed writes and steps; reset mid-sequence restores the reset seeds on the next cycle.

Structure
REQ-029 Package prng_pkg SHALL hold the default POLY/SEED constants, the recommended maximal-length masks for 8/16/24/32 bits, and the step function.
REQ-030 A sub-module prng_channel (one LFSR, its seed register, and wrap compare) SHALL be instantiated CHANNELS times by a generate loop in prng_bank.

Verification
REQ-031 WIDTH=8, POLY=B8, seed 01 on ch0, free-run -> rnd_o ch0 reads B8, 5C, 2E, 17, B3 on consecutive cycles.
REQ-032 Same config, 255 steps -> wrap_o[0] pulses exactly once, on step 255, with the state back at 01; no earlier pulse.
REQ-033 On-demand, req_i=0010 for one cycle -> only ch1 advances; valid_o=0010 for exactly one cycle; other channels are unchanged.
REQ-034 Seed write of 00 to ch2 -> state reads 01; seed write concurrent with req on ch2 -> seed value held, valid_o[2]=0.
REQ-035 Assert wb_rst_i mid free-run with CHANNELS=4, SEED=A5 -> next cycle ch0..3 = A5, A4, A7, A6, and valid_o=0.
REQ-036 en_i=0 for 10 cycles during free-run -> rnd_o frozen and valid_o=0; the sequence resumes without skipping when en_i=1.
